idt_clk_prog: RTL

Parametrised serial programmer for the IDT clock synthesizer on the Pano board. It loads a configuration word of configurable width and shifts it out on `idt_sclk`/`idt_data`, bit order selectable. It then pulses `idt_strobe` to latch the word. The block sits in the `osc_clk` domain next to the board top. It replaces free-running counter-based bring-up programming with a start/busy/done handshake, a programmable serial clock rate and on-demand reprogramming.

---
 rtl/pano_pkg.sv | 30 +++
 rtl/idt_clk_prog_tick_gen.sv | 45 ++++
 rtl/idt_clk_prog.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pano_pkg.sv
// Shared Pano board definitions: programmer FSM states and the IDT clock
// synthesizer configuration word layout.
package pano_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_STROBE = 2'd2
    } idt_state_e;

    localparam int IDT_R_W    = 7;
    localparam int IDT_V_W    = 9;
    localparam int IDT_S_W    = 3;
    localparam int IDT_F_W    = 2;
    localparam int IDT_TTL_W  = 1;
    localparam int IDT_C_W    = 2;
    localparam int IDT_WORD_W = IDT_C_W + IDT_TTL_W + IDT_F_W + IDT_S_W + IDT_V_W + IDT_R_W;

    function automatic logic [IDT_WORD_W-1:0] idt_pack(
        input logic [IDT_C_W-1:0]   c,
        input logic [IDT_TTL_W-1:0] ttl,
        input logic [IDT_F_W-1:0]   f,
        input logic [IDT_S_W-1:0]   s,
        input logic [IDT_V_W-1:0]   v,
        input logic [IDT_R_W-1:0]   r
    );
        return {c, ttl, f, s, v, r};
    endfunction

endpackage

// File: rtl/idt_clk_prog_tick_gen.sv
// Clock-enable divider: tick_o pulses once every CLK_DIV enabled cycles;
// clr_i holds the count at zero so the first half-period is always full length.
module tick_gen #(
    parameter int CLK_DIV = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] CNT_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i & ~clr_i & (cnt_q == CNT_LAST);

    // next divider count, wrapping at CLK_DIV-1
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + DW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // divider count register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/idt_clk_prog.sv
// Serial programmer for the IDT clock synthesizer: shifts a configuration word
// out on idt_sclk/idt_data, then pulses idt_strobe; start/busy/done handshake.
module idt_clk_prog
    import pano_pkg::*;
#(
    parameter int CFG_WIDTH    = 24,
    parameter int CLK_DIV      = 1,
    parameter int MSB_FIRST    = 1,
    parameter int STROBE_TICKS = 2,
    parameter int AUTO_START   = 1
) (
    input  logic                 osc_clk,
    input  logic                 osc_reset,
    input  logic [CFG_WIDTH-1:0] cfg_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 idt_sclk,
    output logic                 idt_data,
    output logic                 idt_strobe
);

    localparam int BW = (CFG_WIDTH > 1) ? $clog2(CFG_WIDTH) : 1;
    localparam int SW = (STROBE_TICKS > 1) ? $clog2(STROBE_TICKS) : 1;
    localparam logic [BW-1:0] BIT_LAST  = BW'(CFG_WIDTH - 1);
    localparam logic [SW-1:0] STRB_LAST = SW'(STROBE_TICKS - 1);

    idt_state_e           state_q, state_d;
    logic [CFG_WIDTH-1:0] sreg_q, sreg_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [SW-1:0]        strb_q, strb_d;
    logic                 phase_q, phase_d;
    logic                 pend_q, pend_d;
    logic                 busy_q, busy_d, done_q, done_d;
    logic                 sclk_q, sclk_d, data_q, data_d, strobe_q, strobe_d;
    logic                 tick_s, cur_bit_s;

    tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk_i  (osc_clk),
        .rst_i  (osc_reset),
        .clr_i  (state_q == ST_IDLE),
        .en_i   (state_q != ST_IDLE),
        .tick_o (tick_s)
    );

    // FSM next state, datapath updates and next registered outputs
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        bit_d   = bit_q;
        strb_d  = strb_q;
        phase_d = phase_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start || pend_q) begin
                    state_d = ST_SHIFT;
                    sreg_d  = cfg_data;
                    bit_d   = '0;
                    strb_d  = '0;
                    phase_d = 1'b0;
                    pend_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!tick_s) begin
                    state_d = ST_SHIFT;
                end else if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_STROBE;
                        strb_d  = '0;
                    end else begin
                        bit_d  = bit_q + BW'(1);
                        sreg_d = (MSB_FIRST != 0) ? (sreg_q << 1) : (sreg_q >> 1);
                    end
                end
            end
            ST_STROBE: begin
                if (!tick_s) begin
                    state_d = ST_STROBE;
                end else if (strb_q == STRB_LAST) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    strb_d = strb_q + SW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (MSB_FIRST != 0) begin
            cur_bit_s = sreg_d[CFG_WIDTH-1];
        end else begin
            cur_bit_s = sreg_d[0];
        end
        // outputs are registered from the next state so they align with it
        busy_d   = (state_d != ST_IDLE);
        sclk_d   = (state_d == ST_SHIFT) & phase_d;
        data_d   = (state_d == ST_SHIFT) & cur_bit_s;
        strobe_d = (state_d == ST_STROBE);
    end

    // state, datapath and output registers; reset abandons any transfer
    always_ff @(posedge osc_clk) begin
        if (osc_reset) begin
            state_q  <= ST_IDLE;
            sreg_q   <= '0;
            bit_q    <= '0;
            strb_q   <= '0;
            phase_q  <= 1'b0;
            pend_q   <= (AUTO_START != 0);
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sclk_q   <= 1'b0;
            data_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            bit_q    <= bit_d;
            strb_q   <= strb_d;
            phase_q  <= phase_d;
            pend_q   <= pend_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sclk_q   <= sclk_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign idt_sclk   = sclk_q;
    assign idt_data   = data_q;
    assign idt_strobe = strobe_q;

endmodule
